// File: rtl/corefifo_reset_sequencer_pkg.sv
// Shared definitions for the FIFO reset sequencer: state encoding and default
// sizing for the source-side reset handshake.
package corefifo_rst_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_ASSERT      = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK_HI = 3'd2;
  localparam logic [2:0] ST_RELEASE     = 3'd3;
  localparam logic [2:0] ST_DONE        = 3'd4;

endpackage

// File: rtl/corefifo_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its control / far-domain
// neighbours; dbg_state mirrors the sequencer FSM for observation.
interface corefifo_reset_sequencer_if;
  import corefifo_rst_pkg::*;

  // Handshake: soft_rst_req is a one-cycle request pulse (no ready; requests
  // while busy are either ignored or collapsed into one pending request).
  // rst_ack_in is a far-domain level answering fifo_rst_n: it goes high after
  // the far side enters reset and low after it leaves; done pulses once per
  // completed sequence.
  logic   soft_rst_req;
  logic   rst_ack_in;
  logic   fifo_rst_n;
  logic   busy;
  logic   done;
  logic   timeout_err;
  state_t dbg_state;

  modport master (
    input  soft_rst_req,
    input  rst_ack_in,
    output fifo_rst_n,
    output busy,
    output done,
    output timeout_err,
    output dbg_state
  );

  modport slave (
    output soft_rst_req,
    output rst_ack_in,
    input  fifo_rst_n,
    input  busy,
    input  done,
    input  timeout_err,
    input  dbg_state
  );

endinterface

// File: rtl/corefifo_rst_ack_sync.sv
// Level synchronizer bringing the far-domain reset acknowledge into clk;
// clears to 0 so a fresh sequence never sees a stale acknowledge.
module corefifo_rst_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/corefifo_reset_sequencer.sv
// Drives an active-low reset into a far-clock-domain FIFO, holds it for a
// minimum time, then waits (with timeout) for the far side to enter and leave reset.
module corefifo_reset_sequencer
  import corefifo_rst_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  corefifo_reset_sequencer_if.master  seq
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             pending, pending_nxt;
  logic             terr, terr_nxt;
  logic             fifo_rst_n_q;
  logic             ack_s;

  corefifo_rst_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (seq.rst_ack_in),
    .q     (ack_s)
  );

  // Saturating so a long wait can never wrap back through the compare values.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_inc;
    pending_nxt = pending;
    terr_nxt    = terr;
    case (state)
      ST_IDLE: begin
        cnt_nxt = cnt;
        if (seq.soft_rst_req || pending) begin
          state_nxt   = ST_ASSERT;
          pending_nxt = 1'b0;
          cnt_nxt     = '0;
          terr_nxt    = 1'b0;
        end
      end
      ST_ASSERT: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_WAIT_ACK_HI;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_ACK_HI: begin
        if (ack_s) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
          terr_nxt  = 1'b1;
        end
      end
      ST_RELEASE: begin
        // The far side is already coming out of reset, so a new request must
        // wait for a full fresh sequence.
        if (seq.soft_rst_req) pending_nxt = 1'b1;
        if (!ack_s) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          terr_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        if (seq.soft_rst_req) pending_nxt = 1'b1;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      pending      <= 1'b0;
      terr         <= 1'b0;
      fifo_rst_n_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pending      <= pending_nxt;
      terr         <= terr_nxt;
      fifo_rst_n_q <= !((state_nxt == ST_ASSERT) || (state_nxt == ST_WAIT_ACK_HI));
    end
  end

  assign seq.fifo_rst_n  = fifo_rst_n_q;
  assign seq.busy        = (state != ST_IDLE);
  assign seq.done        = (state == ST_DONE);
  assign seq.timeout_err = terr;
  assign seq.dbg_state   = state;

endmodule

// File: tb/tb_corefifo_reset_sequencer.sv
// Directed bench for corefifo_reset_sequencer: each stimulus pushes the expected
// {timeout_err, fifo_rst_n low length} for its done pulse; a monitor pops on done.
module tb_corefifo_reset_sequencer;
  import corefifo_rst_pkg::*;

  localparam int SB_W = 9;
  localparam int ACK_LOW = 0;
  localparam int ACK_D1  = 1;
  localparam int ACK_D3  = 2;
  localparam int ACK_MAN = 3;

  logic clk;
  logic reset;
  int   ack_mode;
  logic ack_man;
  logic [2:0] ack_dly;

  logic [SB_W-1:0] exp_q[$];
  int n_checks;
  int n_pass;
  int low_cnt;
  int last_low;
  logic fifo_prev;
  logic done_prev;

  corefifo_reset_sequencer_if seq_if();

  corefifo_reset_sequencer #(
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .seq   (seq_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Far-side model: acknowledge follows !fifo_rst_n with a 1- or 3-cycle lag.
  always @(posedge clk or negedge reset) begin
    if (!reset) ack_dly <= '0;
    else        ack_dly <= {ack_dly[1:0], ~seq_if.fifo_rst_n};
  end

  always_comb begin
    case (ack_mode)
      ACK_D1:  seq_if.rst_ack_in = ack_dly[0];
      ACK_D3:  seq_if.rst_ack_in = ack_dly[2];
      ACK_MAN: seq_if.rst_ack_in = ack_man;
      default: seq_if.rst_ack_in = 1'b0;
    endcase
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      low_cnt   = 0;
      fifo_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) begin
        check("post_done_busy", 16'(seq_if.busy), 16'd0);
        check("post_done_pulse", 16'(seq_if.done), 16'd0);
      end
      if (!seq_if.fifo_rst_n) begin
        low_cnt++;
      end else if (!fifo_prev) begin
        last_low = low_cnt;
        low_cnt  = 0;
      end
      fifo_prev = seq_if.fifo_rst_n;
      if (seq_if.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done pulse expected none at %0t", $time);
        end else begin
          check("done_record", 16'({seq_if.timeout_err, 8'(last_low)}), 16'(exp_q.pop_front()));
        end
      end
      done_prev = (seq_if.done === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    @(posedge clk); #1 seq_if.soft_rst_req = 1'b1;
    @(posedge clk); #1 seq_if.soft_rst_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && seq_if.dbg_state == ST_IDLE) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_idle: got %0d pending records expected 0 within %0d cycles", exp_q.size(), max_cyc);
    end
  endtask

  task automatic wait_state(input state_t st, input int max_cyc);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (seq_if.dbg_state == st) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", seq_if.dbg_state, st, max_cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_low = 0;
    reset    = 1'b0;
    ack_mode = ACK_D3;
    ack_man  = 1'b0;
    seq_if.soft_rst_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_rst_n", 16'(seq_if.fifo_rst_n), 16'd0);
    check("rst_busy", 16'(seq_if.busy), 16'd1);
    check("rst_done", 16'(seq_if.done), 16'd0);
    check("rst_timeout_err", 16'(seq_if.timeout_err), 16'd0);
    check("rst_state", 16'(seq_if.dbg_state), 16'(ST_ASSERT));

    // 1. power-on: hold 4, ack_s high 2 cycles into the wait -> 6 cycles low
    exp_q.push_back({1'b0, 8'd6});
    @(posedge clk); #2 reset = 1'b1;
    wait_idle(100);
    check("po_idle_timeout_err", 16'(seq_if.timeout_err), 16'd0);
    check("po_idle_fifo_rst_n", 16'(seq_if.fifo_rst_n), 16'd1);

    // 2. soft reset with a 1-cycle far side: ack_s already high at hold end -> 5 low
    ack_mode = ACK_D1;
    exp_q.push_back({1'b0, 8'd5});
    pulse_req();
    check("soft_fifo_low", 16'(seq_if.fifo_rst_n), 16'd0);
    check("soft_busy", 16'(seq_if.busy), 16'd1);
    wait_idle(100);

    // 3. ack never arrives: 4 hold + 16 timeout low, sticky error
    ack_mode = ACK_LOW;
    exp_q.push_back({1'b1, 8'd20});
    pulse_req();
    wait_idle(100);
    repeat (3) @(posedge clk);
    #1 check("timeout_sticky", 16'(seq_if.timeout_err), 16'd1);

    // 4. request in ASSERT ignored; two in RELEASE collapse to one extra sequence
    ack_mode = ACK_D3;
    exp_q.push_back({1'b0, 8'd6});
    exp_q.push_back({1'b0, 8'd6});
    pulse_req();
    check("new_seq_clears_err", 16'(seq_if.timeout_err), 16'd0);
    pulse_req();
    wait_state(ST_RELEASE, 50);
    pulse_req();
    pulse_req();
    wait_idle(200);
    repeat (5) @(posedge clk);
    #1 check("no_third_seq", 16'(seq_if.busy), 16'd0);

    // 5. async reset during WAIT_ACK_HI aborts without done
    ack_mode = ACK_LOW;
    pulse_req();
    wait_state(ST_WAIT_ACK_HI, 50);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("abort_fifo_rst_n", 16'(seq_if.fifo_rst_n), 16'd0);
    check("abort_busy", 16'(seq_if.busy), 16'd1);
    check("abort_done", 16'(seq_if.done), 16'd0);
    check("abort_state", 16'(seq_if.dbg_state), 16'(ST_ASSERT));
    ack_mode = ACK_D3;
    repeat (2) @(posedge clk);
    exp_q.push_back({1'b0, 8'd6});
    @(posedge clk); #2 reset = 1'b1;
    wait_idle(100);

    // 6. one-cycle ack glitch in the wait, then steady high: one done, 7 low
    ack_mode = ACK_MAN;
    ack_man  = 1'b0;
    exp_q.push_back({1'b0, 8'd7});
    pulse_req();
    repeat (4) @(posedge clk);
    #1 ack_man = 1'b1;
    @(posedge clk); #1 ack_man = 1'b0;
    @(posedge clk); #1 ack_man = 1'b1;
    wait_idle(100);
    ack_man = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("glitch_idle_busy", 16'(seq_if.busy), 16'd0);

    check("sb_drain", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
